// File: rtl/jzjpcc_pc_pkg.sv
// Shared types for the fetch PC unit: word-aligned PC type and redirect source encoding.
package jzjpcc_pc_pkg;

    localparam int DEF_PC_MAX_B = 31;
    localparam int DEF_RAS_DEPTH = 4;

    typedef logic [DEF_PC_MAX_B:2] pc_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_DEC_JUMP,
        SRC_RAS,
        SRC_EX,
        SRC_TRAP
    } redirect_src_t;

    // Width of the RAS occupancy counter: must be able to hold RAS_DEPTH itself.
    function automatic int ras_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jzjpcc_pc_unit_if.sv
// Fetch PC unit bus: redirect requests from decode/execute/trap in, fetch PCs and RAS occupancy out.
interface jzjpcc_pc_unit_if
    import jzjpcc_pc_pkg::*;
#(
    parameter int PC_MAX_B  = DEF_PC_MAX_B,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
);
    localparam int CW = ras_count_width(RAS_DEPTH);

    logic                initialize;
    logic                stall_fetch;
    logic                trap_valid;
    logic [PC_MAX_B:2]   trap_pc;
    logic                ex_redirect_valid;
    logic [PC_MAX_B:2]   ex_redirect_pc;
    logic                dec_jump_valid;
    logic [PC_MAX_B:2]   dec_jump_pc;
    logic                dec_call;
    logic                dec_ret;
    logic [PC_MAX_B:2]   dec_pc;
    logic [PC_MAX_B:2]   currentPC_fetch;
    logic [PC_MAX_B:2]   nextPC;
    logic [CW-1:0]       ras_count;

    modport master (
        output initialize, stall_fetch,
        output trap_valid, trap_pc,
        output ex_redirect_valid, ex_redirect_pc,
        output dec_jump_valid, dec_jump_pc,
        output dec_call, dec_ret, dec_pc,
        input  currentPC_fetch, nextPC, ras_count
    );

    modport slave (
        input  initialize, stall_fetch,
        input  trap_valid, trap_pc,
        input  ex_redirect_valid, ex_redirect_pc,
        input  dec_jump_valid, dec_jump_pc,
        input  dec_call, dec_ret, dec_pc,
        output currentPC_fetch, nextPC, ras_count
    );

endinterface

// File: rtl/jzjpcc_ras.sv
// Circular return-address stack. Push past full overwrites the oldest entry;
// push+pop together replaces the top in place.
module jzjpcc_ras
    import jzjpcc_pc_pkg::*;
#(
    parameter int PC_MAX_B  = DEF_PC_MAX_B,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH,
    localparam int CW       = ras_count_width(RAS_DEPTH),
    localparam int PTR_W    = $clog2(RAS_DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_MAX_B:2]   push_pc,
    output logic [PC_MAX_B:2]   top,
    output logic [CW-1:0]       count
);

    logic [PC_MAX_B:2] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_top;
    logic              pop_ok;
    logic              replace;
    logic              push_only;
    logic              pop_only;

    // ptr points at the next free slot; the top lives one below it (wrapping).
    assign ptr_top   = ptr - PTR_W'(1);
    assign pop_ok    = pop && (count != '0);
    assign replace   = push && pop_ok;
    assign push_only = push && !pop_ok;
    assign pop_only  = pop_ok && !push;
    assign top       = mem[ptr_top];

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clock) begin
        if (replace) begin
            mem[ptr_top] <= push_pc;
        end else if (push_only) begin
            mem[ptr] <= push_pc;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push_only) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CW'(RAS_DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop_only) begin
            ptr   <= ptr_top;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/jzjpcc_pc_unit.sv
// Fetch-stage PC generator: prioritised redirect mux, pending redirect held
// across stalls, and a RAS for call/return prediction.
module jzjpcc_pc_unit
    import jzjpcc_pc_pkg::*;
#(
    parameter int          PC_MAX_B     = DEF_PC_MAX_B,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic           clock,
    input  logic           reset,
    jzjpcc_pc_unit_if.slave bus
);

    typedef logic [PC_MAX_B:2] lpc_t;

    lpc_t          cur_pc;
    lpc_t          next_pc;
    logic          pend_valid;
    lpc_t          pend_pc;
    redirect_src_t sel_src;
    lpc_t          sel_pc;
    logic          eff_valid;
    lpc_t          eff_pc;
    logic          hold;
    logic          squash;
    logic          ras_push;
    logic          ras_pop;
    lpc_t          ras_top;
    logic [ras_count_width(RAS_DEPTH)-1:0] ras_count;

    assign hold   = bus.initialize | bus.stall_fetch;
    // Older-instruction redirects kill whatever decode is doing this cycle.
    assign squash = bus.trap_valid | bus.ex_redirect_valid;

    assign ras_push = bus.dec_call & ~squash;
    assign ras_pop  = bus.dec_ret & ~squash;

    jzjpcc_ras #(
        .PC_MAX_B  (PC_MAX_B),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .push    (ras_push),
        .pop     (ras_pop),
        .push_pc (bus.dec_pc + lpc_t'(1)),
        .top     (ras_top),
        .count   (ras_count)
    );

    // Fixed-priority redirect selection; a return with an empty RAS falls through.
    always_comb begin
        sel_src = SRC_NONE;
        sel_pc  = '0;
        if (bus.trap_valid) begin
            sel_src = SRC_TRAP;
            sel_pc  = bus.trap_pc;
        end else if (bus.ex_redirect_valid) begin
            sel_src = SRC_EX;
            sel_pc  = bus.ex_redirect_pc;
        end else if (bus.dec_ret && (ras_count != '0)) begin
            sel_src = SRC_RAS;
            sel_pc  = ras_top;
        end else if (bus.dec_jump_valid) begin
            sel_src = SRC_DEC_JUMP;
            sel_pc  = bus.dec_jump_pc;
        end
    end

    // This cycle's request beats anything pending (youngest request wins).
    always_comb begin
        eff_valid = pend_valid;
        eff_pc    = pend_pc;
        if (sel_src != SRC_NONE) begin
            eff_valid = 1'b1;
            eff_pc    = sel_pc;
        end
        if (hold) begin
            next_pc = cur_pc;
        end else if (eff_valid) begin
            next_pc = eff_pc;
        end else begin
            next_pc = cur_pc + lpc_t'(1);
        end
    end

    // PC register and pending redirect latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_pc     <= RESET_VECTOR[PC_MAX_B:2];
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (hold) begin
            pend_valid <= eff_valid;
            pend_pc    <= eff_pc;
        end else begin
            cur_pc     <= next_pc;
            pend_valid <= 1'b0;
        end
    end

    assign bus.currentPC_fetch = cur_pc;
    assign bus.nextPC          = next_pc;
    assign bus.ras_count       = ras_count;

endmodule

// File: tb/tb_jzjpcc_pc_unit.sv
// Bench for jzjpcc_pc_unit: directed vector table, reset-during-stall sequence,
// then random stimulus against a queue-based reference model.
module tb_jzjpcc_pc_unit;
    import jzjpcc_pc_pkg::*;

    localparam int DEPTH = 4;
    typedef logic [29:0] p_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    jzjpcc_pc_unit_if #(.PC_MAX_B(31), .RAS_DEPTH(DEPTH)) bus ();

    jzjpcc_pc_unit #(
        .PC_MAX_B     (31),
        .RESET_VECTOR (32'h0000_0100),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic st;  logic in;
        logic tv;  p_t tp;
        logic ev;  p_t ep;
        logic jv;  p_t jp;
        logic cl;  logic rt; p_t dp;
        p_t   e_next; p_t e_cur; int e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic in, input logic tv, input p_t tp,
                       input logic ev, input p_t ep, input logic jv, input p_t jp,
                       input logic cl, input logic rt, input p_t dp,
                       input p_t e_next, input p_t e_cur, input int e_cnt);
        vec_t v;
        v.st = st; v.in = in; v.tv = tv; v.tp = tp; v.ev = ev; v.ep = ep;
        v.jv = jv; v.jp = jp; v.cl = cl; v.rt = rt; v.dp = dp;
        v.e_next = e_next; v.e_cur = e_cur; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic in, input logic tv, input p_t tp,
                         input logic ev, input p_t ep, input logic jv, input p_t jp,
                         input logic cl, input logic rt, input p_t dp);
        bus.stall_fetch       = st;
        bus.initialize        = in;
        bus.trap_valid        = tv;
        bus.trap_pc           = tp;
        bus.ex_redirect_valid = ev;
        bus.ex_redirect_pc    = ep;
        bus.dec_jump_valid    = jv;
        bus.dec_jump_pc       = jp;
        bus.dec_call          = cl;
        bus.dec_ret           = rt;
        bus.dec_pc            = dp;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain PC, pending slot, and RAS as a bounded queue.
    p_t m_cur;
    logic m_pv;
    p_t m_pp;
    p_t m_q[$];

    task automatic model_reset();
        m_cur = 30'h40;
        m_pv  = 1'b0;
        m_pp  = '0;
        m_q.delete();
    endtask

    task automatic model_cycle(output p_t exp_next);
        logic squash, hold, have;
        p_t   tgt;
        squash = bus.trap_valid | bus.ex_redirect_valid;
        hold   = bus.initialize | bus.stall_fetch;
        have   = 1'b1;
        tgt    = '0;
        if (bus.trap_valid)                          tgt = bus.trap_pc;
        else if (bus.ex_redirect_valid)              tgt = bus.ex_redirect_pc;
        else if (bus.dec_ret && m_q.size() > 0)      tgt = m_q[m_q.size()-1];
        else if (bus.dec_jump_valid)                 tgt = bus.dec_jump_pc;
        else if (m_pv)                               tgt = m_pp;
        else                                         have = 1'b0;
        if (hold)      exp_next = m_cur;
        else if (have) exp_next = tgt;
        else           exp_next = m_cur + 30'd1;
        if (!squash) begin
            if (bus.dec_call && bus.dec_ret && m_q.size() > 0) begin
                m_q[m_q.size()-1] = bus.dec_pc + 30'd1;
            end else if (bus.dec_call) begin
                m_q.push_back(bus.dec_pc + 30'd1);
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
            end else if (bus.dec_ret && m_q.size() > 0) begin
                void'(m_q.pop_back());
            end
        end
        if (hold) begin
            m_pv = have;
            m_pp = tgt;
        end else begin
            m_cur = exp_next;
            m_pv  = 1'b0;
        end
    endtask

    initial begin
        p_t exp_next;
        idle();

        //   st in tv tp     ev ep      jv jp          cl rt dp      next         cur          cnt
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h41,      30'h40,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h42,      30'h41,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h43,      30'h42,      0);
        add(0, 0, 1, 30'h10, 1, 30'h20, 1, 30'h30,    1, 0, 30'h77, 30'h10,      30'h43,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h11,      30'h10,      0);
        add(1, 0, 0, 0,     1, 30'h55, 0, 0,          0, 0, 0,      30'h11,      30'h11,      0);
        add(1, 0, 0, 0,     0, 0,      1, 30'h66,     0, 0, 0,      30'h11,      30'h11,      0);
        add(1, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h11,      30'h11,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h66,      30'h11,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 0, 30'h80, 30'h67,      30'h66,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h68,      30'h67,      1);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 1, 30'h99, 30'h81,      30'h68,      1);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h82,      30'h81,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 0, 30'h0,  30'h83,      30'h82,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 0, 30'h1,  30'h84,      30'h83,      1);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 0, 30'h2,  30'h85,      30'h84,      2);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 0, 30'h3,  30'h86,      30'h85,      3);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 0, 30'h4,  30'h87,      30'h86,      4);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 1, 0,      30'h5,       30'h87,      4);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 1, 0,      30'h4,       30'h5,       3);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 1, 0,      30'h3,       30'h4,       2);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 1, 0,      30'h2,       30'h3,       1);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 1, 0,      30'h3,       30'h2,       0);
        add(0, 0, 0, 0,     0, 0,      1, 30'h40,     0, 1, 0,      30'h40,      30'h3,       0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 0, 30'h80, 30'h41,      30'h40,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 1, 30'h90, 30'h81,      30'h41,      1);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h82,      30'h81,      1);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 1, 0,      30'h91,      30'h82,      1);
        add(0, 0, 0, 0,     0, 0,      0, 0,          1, 1, 30'h20, 30'h92,      30'h91,      0);
        add(0, 0, 0, 0,     1, 30'h200, 0, 0,         0, 1, 0,      30'h200,     30'h92,      1);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 1, 0,      30'h21,      30'h200,     1);
        add(0, 1, 1, 30'h300, 0, 0,    0, 0,          0, 0, 0,      30'h21,      30'h21,      0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h300,     30'h21,      0);
        add(0, 0, 0, 0,     0, 0,      1, 30'h3FFFFFFF, 0, 0, 0,    30'h3FFFFFFF, 30'h300,    0);
        add(0, 0, 0, 0,     0, 0,      0, 0,          0, 0, 0,      30'h0,       30'h3FFFFFFF, 0);

        // Reset value while held in reset.
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_cur", 32'(bus.currentPC_fetch), 32'h40);
        check("reset_cnt", 32'(bus.ras_count), 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].in, vecs[i].tv, vecs[i].tp, vecs[i].ev, vecs[i].ep,
                  vecs[i].jv, vecs[i].jp, vecs[i].cl, vecs[i].rt, vecs[i].dp);
            @(negedge clock);
            check($sformatf("v%0d_next", i), 32'(bus.nextPC), 32'(vecs[i].e_next));
            check($sformatf("v%0d_cur", i), 32'(bus.currentPC_fetch), 32'(vecs[i].e_cur));
            check($sformatf("v%0d_cnt", i), 32'(bus.ras_count), 32'(vecs[i].e_cnt));
            @(posedge clock);
            #1;
        end

        // Reset arriving mid-stall wipes the pending redirect and the RAS immediately.
        drive(0, 0, 0, '0, 0, '0, 0, '0, 1, 0, 30'h10);
        @(posedge clock); #1;
        drive(1, 0, 0, '0, 1, 30'h55, 0, '0, 0, 0, '0);
        @(posedge clock); #1;
        drive(1, 0, 0, '0, 0, '0, 0, '0, 0, 0, '0);
        reset = 1'b0;
        #2;
        check("midrst_cur", 32'(bus.currentPC_fetch), 32'h40);
        check("midrst_cnt", 32'(bus.ras_count), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        drive(0, 0, 0, '0, 0, '0, 0, '0, 0, 1, '0);
        @(negedge clock);
        check("midrst_next", 32'(bus.nextPC), 32'h41);
        @(posedge clock); #1;
        idle();

        // Random stimulus against the reference model.
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(99) < 25), ($urandom_range(99) < 5),
                  ($urandom_range(99) < 5), p_t'($urandom),
                  ($urandom_range(99) < 8), p_t'($urandom),
                  ($urandom_range(99) < 15), p_t'($urandom),
                  ($urandom_range(99) < 20), ($urandom_range(99) < 20),
                  p_t'($urandom));
            @(negedge clock);
            check("rnd_cur", 32'(bus.currentPC_fetch), 32'(m_cur));
            check("rnd_cnt", 32'(bus.ras_count), 32'(m_q.size()));
            model_cycle(exp_next);
            check("rnd_next", 32'(bus.nextPC), 32'(exp_next));
            @(posedge clock);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
